// File: rtl/locals_frame_stack.sv
// locals_frame_stack: typed local-variable store for the wasm CPU, one frame per active call.
// Latency: GET/POP respond 2 cycles after accept, SET/TEE 3, PUSH_FRAME N at N+2; rsp_valid is a 1-cycle strobe.
// Backpressure: cmd_ready drops while a command is in flight and returns with rsp_valid; a trap holds it low until reset.
module locals_frame_stack #(
  parameter int LOCALS_DEPTH = 7,
  parameter int FRAMES_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [LOCALS_DEPTH:0] cmd_index,
  input  logic [63:0]           cmd_data,
  input  logic [1:0]            cmd_type,
  output logic                  rsp_valid,
  output logic [63:0]           rsp_data,
  output logic [1:0]            rsp_type,
  output logic [FRAMES_DEPTH:0] frame_depth,
  output logic [3:0]            trap
);

  localparam int SLOTS  = 1 << LOCALS_DEPTH;
  localparam int FRAMES = 1 << FRAMES_DEPTH;
  // Slot count and frame count limits, in the widths they are compared at.
  localparam logic [LOCALS_DEPTH+1:0] SLOTS_EXT   = {2'b01, {LOCALS_DEPTH{1'b0}}};
  localparam logic [FRAMES_DEPTH:0]   FRAMES_FULL = {1'b1, {FRAMES_DEPTH{1'b0}}};

  localparam logic [2:0] OP_GET  = 3'd0;
  localparam logic [2:0] OP_SET  = 3'd1;
  localparam logic [2:0] OP_TEE  = 3'd2;
  localparam logic [2:0] OP_PUSH = 3'd3;
  localparam logic [2:0] OP_POP  = 3'd4;

  localparam logic [3:0] TRAP_NONE = 4'd0;
  localparam logic [3:0] TRAP_OOB  = 4'd1;
  localparam logic [3:0] TRAP_OVF  = 4'd2;
  localparam logic [3:0] TRAP_UNF  = 4'd3;
  localparam logic [3:0] TRAP_TYPE = 4'd4;
  localparam logic [3:0] TRAP_OP   = 4'd5;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WRITE, S_CLEAR, S_RESP, S_TRAP
  } state_t;

  state_t state;

  // Command captured at acceptance.
  logic [2:0]              op_q;
  logic [LOCALS_DEPTH:0]   idx_q;
  logic [63:0]             data_q;
  logic [1:0]              type_q;

  // Current frame window and clear progress.
  logic [LOCALS_DEPTH:0]   base;
  logic [LOCALS_DEPTH:0]   size;
  logic [LOCALS_DEPTH:0]   clr_cnt;

  // Local slot storage (type codes are opaque and only compared for equality).
  logic [63:0]             ram_data [SLOTS];
  logic [1:0]              ram_type [SLOTS];

  // Saved caller window, indexed by the depth at which it was pushed.
  logic [LOCALS_DEPTH:0]   fstk_base [FRAMES];
  logic [LOCALS_DEPTH:0]   fstk_size [FRAMES];

  logic [LOCALS_DEPTH-1:0] lcl_addr;
  logic [LOCALS_DEPTH-1:0] clr_addr;
  logic [LOCALS_DEPTH+1:0] push_end;
  logic [FRAMES_DEPTH-1:0] pop_idx;
  logic                    idx_oob;
  logic                    push_fault;
  logic                    clr_last;
  logic                    push_commit;
  logic                    mem_we;
  logic [LOCALS_DEPTH-1:0] mem_addr;
  logic [63:0]             mem_wdata;
  logic [1:0]              mem_wtype;

  // Address generation, bounds checks and the single RAM write port mux.
  // Slot addresses are formed modulo SLOTS: bounds checks guarantee the true sum never exceeds it.
  always_comb begin
    lcl_addr    = base[LOCALS_DEPTH-1:0] + idx_q[LOCALS_DEPTH-1:0];
    clr_addr    = base[LOCALS_DEPTH-1:0] + size[LOCALS_DEPTH-1:0] + clr_cnt[LOCALS_DEPTH-1:0];
    push_end    = {1'b0, base} + {1'b0, size} + {1'b0, idx_q};
    idx_oob     = (frame_depth == '0) || (idx_q >= size);
    push_fault  = (frame_depth == FRAMES_FULL) || (push_end > SLOTS_EXT);
    clr_last    = (clr_cnt == idx_q - 1'b1);
    pop_idx     = frame_depth[FRAMES_DEPTH-1:0] - 1'b1;
    push_commit = ((state == S_READ) && (op_q == OP_PUSH) && !push_fault && (idx_q == '0))
                || ((state == S_CLEAR) && clr_last);
    mem_we      = 1'b0;
    mem_addr    = lcl_addr;
    mem_wdata   = data_q;
    mem_wtype   = type_q;
    if (state == S_WRITE) begin
      mem_we = 1'b1;
    end else if (state == S_CLEAR) begin
      mem_we    = 1'b1;
      mem_addr  = clr_addr;
      mem_wdata = '0;
    end
  end

  // Control FSM with registered handshake, response and trap outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_type    <= '0;
      frame_depth <= '0;
      trap        <= TRAP_NONE;
      op_q        <= OP_GET;
      idx_q       <= '0;
      data_q      <= '0;
      type_q      <= '0;
      base        <= '0;
      size        <= '0;
      clr_cnt     <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_type  <= '0;
      case (state)
        S_IDLE, S_RESP: begin
          if (cmd_valid && cmd_ready) begin
            op_q      <= cmd_op;
            idx_q     <= cmd_index;
            data_q    <= cmd_data;
            type_q    <= cmd_type;
            state     <= S_READ;
            cmd_ready <= 1'b0;
          end else begin
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
          end
        end
        S_READ: begin
          case (op_q)
            OP_GET: begin
              if (idx_oob) begin
                state <= S_TRAP;
                trap  <= TRAP_OOB;
              end else begin
                state     <= S_RESP;
                cmd_ready <= 1'b1;
                rsp_valid <= 1'b1;
                rsp_data  <= ram_data[lcl_addr];
                rsp_type  <= ram_type[lcl_addr];
              end
            end
            OP_SET, OP_TEE: begin
              if (idx_oob) begin
                state <= S_TRAP;
                trap  <= TRAP_OOB;
              end else if (ram_type[lcl_addr] != type_q) begin
                state <= S_TRAP;
                trap  <= TRAP_TYPE;
              end else begin
                state <= S_WRITE;
              end
            end
            OP_PUSH: begin
              if (push_fault) begin
                state <= S_TRAP;
                trap  <= TRAP_OVF;
              end else if (push_commit) begin
                // Empty frame: nothing to clear, open it straight away.
                base        <= base + size;
                size        <= idx_q;
                frame_depth <= frame_depth + 1'b1;
                state       <= S_RESP;
                cmd_ready   <= 1'b1;
                rsp_valid   <= 1'b1;
              end else begin
                clr_cnt <= '0;
                state   <= S_CLEAR;
              end
            end
            OP_POP: begin
              if (frame_depth == '0) begin
                state <= S_TRAP;
                trap  <= TRAP_UNF;
              end else begin
                base        <= fstk_base[pop_idx];
                size        <= fstk_size[pop_idx];
                frame_depth <= frame_depth - 1'b1;
                state       <= S_RESP;
                cmd_ready   <= 1'b1;
                rsp_valid   <= 1'b1;
              end
            end
            default: begin
              state <= S_TRAP;
              trap  <= TRAP_OP;
            end
          endcase
        end
        S_WRITE: begin
          state     <= S_RESP;
          cmd_ready <= 1'b1;
          rsp_valid <= 1'b1;
          if (op_q == OP_TEE) begin
            rsp_data <= data_q;
            rsp_type <= type_q;
          end
        end
        S_CLEAR: begin
          if (push_commit) begin
            base        <= base + size;
            size        <= idx_q;
            frame_depth <= frame_depth + 1'b1;
            state       <= S_RESP;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        S_TRAP: begin
          state     <= S_TRAP;
          cmd_ready <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Local slot writes from SET/TEE and frame clearing; suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (reset && mem_we) begin
      ram_data[mem_addr] <= mem_wdata;
      ram_type[mem_addr] <= mem_wtype;
    end
  end

  // Save the caller window when a new frame is committed.
  always_ff @(posedge clk) begin
    if (reset && push_commit) begin
      fstk_base[frame_depth[FRAMES_DEPTH-1:0]] <= base;
      fstk_size[frame_depth[FRAMES_DEPTH-1:0]] <= size;
    end
  end

endmodule

// File: tb/tb_locals_frame_stack.sv
// tb_locals_frame_stack: directed scenarios plus random command streams against a frame/slot reference model.
// Checks response latency, data, type, frame depth, trap codes and reset behaviour.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_locals_frame_stack;

  localparam logic [1:0] I32 = 2'd0;
  localparam logic [1:0] I64 = 2'd1;
  localparam logic [1:0] F32 = 2'd2;
  localparam logic [1:0] F64 = 2'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [7:0]  cmd_index = 8'd0;
  logic [63:0] cmd_data = 64'd0;
  logic [1:0]  cmd_type = 2'd0;
  logic        rsp_valid;
  logic [63:0] rsp_data;
  logic [1:0]  rsp_type;
  logic [4:0]  frame_depth;
  logic [3:0]  trap;

  int checks = 0;
  int failures = 0;

  // Reference model: flat slot memory plus a stack of (base, size) frames.
  logic [63:0] m_data [128];
  logic [1:0]  m_type [128];
  int          fr_base[$];
  int          fr_size[$];
  logic [63:0] last_data;
  logic [1:0]  last_type;

  always #5 clk = ~clk;

  locals_frame_stack #(.LOCALS_DEPTH(7), .FRAMES_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_index(cmd_index), .cmd_data(cmd_data), .cmd_type(cmd_type),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_type(rsp_type),
    .frame_depth(frame_depth), .trap(trap)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int cur_base();
    return (fr_base.size() == 0) ? 0 : fr_base[fr_base.size()-1];
  endfunction

  function automatic int cur_size();
    return (fr_size.size() == 0) ? 0 : fr_size[fr_size.size()-1];
  endfunction

  // Apply one command to the model; returns the expected trap, latency and response.
  task automatic model_step(input logic [2:0] op, input int idx, input logic [63:0] data,
                            input logic [1:0] typ, output int e_trap, output int e_lat,
                            output logic [63:0] e_data, output logic [1:0] e_type);
    int depth, b, s, nb;
    depth = fr_base.size();
    b = cur_base();
    s = cur_size();
    e_trap = 0; e_lat = 0; e_data = 64'd0; e_type = 2'd0;
    case (op)
      3'd0: begin
        if (depth == 0 || idx >= s) e_trap = 1;
        else begin e_lat = 2; e_data = m_data[b+idx]; e_type = m_type[b+idx]; end
      end
      3'd1, 3'd2: begin
        if (depth == 0 || idx >= s) e_trap = 1;
        else if (m_type[b+idx] != typ) e_trap = 4;
        else begin
          m_data[b+idx] = data;
          m_type[b+idx] = typ;
          e_lat = 3;
          if (op == 3'd2) begin e_data = data; e_type = typ; end
        end
      end
      3'd3: begin
        nb = b + s;
        if (depth == 16 || nb + idx > 128) e_trap = 2;
        else begin
          for (int k = 0; k < idx; k++) begin m_data[nb+k] = 64'd0; m_type[nb+k] = typ; end
          fr_base.push_back(nb);
          fr_size.push_back(idx);
          e_lat = idx + 2;
        end
      end
      3'd4: begin
        if (depth == 0) e_trap = 3;
        else begin void'(fr_base.pop_back()); void'(fr_size.pop_back()); e_lat = 2; end
      end
      default: e_trap = 5;
    endcase
  endtask

  task automatic pulse_reset();
    cmd_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    fr_base.delete();
    fr_size.delete();
    check_eq("rst_trap", trap, 0);
    check_eq("rst_ready", cmd_ready, 1);
    check_eq("rst_depth", frame_depth, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
  endtask

  // Issue one command and check it against the model; a trapping command ends with a reset pulse.
  task automatic run_cmd(input logic [2:0] op, input int idx, input logic [63:0] data, input logic [1:0] typ);
    int e_trap, e_lat, cyc, w;
    logic [63:0] e_data;
    logic [1:0] e_type;
    model_step(op, idx, data, typ, e_trap, e_lat, e_data, e_type);
    cmd_valid = 1'b1; cmd_op = op; cmd_index = 8'(idx); cmd_data = data; cmd_type = typ;
    w = 0;
    while (!cmd_ready && w < 20) begin @(negedge clk); w++; end
    if (!cmd_ready) begin
      check_eq("accept", cmd_ready, 1);
      cmd_valid = 1'b0;
      pulse_reset();
      return;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc = 1;
    while (!rsp_valid && trap == 4'd0 && cyc < 300) begin @(negedge clk); cyc++; end
    last_data = rsp_data;
    last_type = rsp_type;
    if (e_trap == 0) begin
      check_eq("rsp_lat", cyc, e_lat);
      check_eq("rsp_valid", rsp_valid, 1);
      check_eq("rsp_data", rsp_data, e_data);
      check_eq("rsp_type", rsp_type, e_type);
      check_eq("depth", frame_depth, fr_base.size());
      check_eq("no_trap", trap, 0);
      check_eq("ready_on_rsp", cmd_ready, 1);
    end else begin
      check_eq("trap_code", trap, e_trap);
      check_eq("trap_cycle", cyc, 2);
      check_eq("trap_no_rsp", rsp_valid, 0);
      check_eq("trap_ready", cmd_ready, 0);
      @(negedge clk);
      check_eq("trap_sticky", trap, e_trap);
      pulse_reset();
    end
  endtask

  initial begin
    int r, s, d, idx;
    logic [1:0] typ;
    logic saw;

    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("init_ready", cmd_ready, 1);
    check_eq("init_rsp_valid", rsp_valid, 0);
    check_eq("init_rsp_data", rsp_data, 0);
    check_eq("init_rsp_type", rsp_type, 0);
    check_eq("init_depth", frame_depth, 0);
    check_eq("init_trap", trap, 0);
    reset = 1'b1;
    @(negedge clk);

    // 1: set then get in an i64 frame
    run_cmd(3'd3, 2, 64'd0, I64);
    run_cmd(3'd1, 1, 64'd3, I64);
    run_cmd(3'd0, 1, 64'd0, I64);
    check_eq("t1_data", last_data, 3);
    check_eq("t1_type", last_type, I64);
    check_eq("t1_depth", frame_depth, 1);
    pulse_reset();

    // 2: zero-initialised slot, tee, get
    run_cmd(3'd3, 2, 64'd0, I32);
    run_cmd(3'd0, 0, 64'd0, I32);
    check_eq("t2_zero", last_data, 0);
    run_cmd(3'd2, 0, 64'd7, I32);
    check_eq("t2_tee", last_data, 7);
    run_cmd(3'd0, 0, 64'd0, I32);
    check_eq("t2_get", last_data, 7);
    pulse_reset();

    // 3: nested frames preserve the caller's locals
    run_cmd(3'd3, 3, 64'd0, I64);
    run_cmd(3'd1, 2, 64'd5, I64);
    run_cmd(3'd3, 1, 64'd0, I64);
    check_eq("t3_depth2", frame_depth, 2);
    run_cmd(3'd1, 0, 64'd9, I64);
    run_cmd(3'd4, 0, 64'd0, I64);
    check_eq("t3_depth1", frame_depth, 1);
    run_cmd(3'd0, 2, 64'd0, I64);
    check_eq("t3_data", last_data, 5);
    pulse_reset();

    // 4: type mismatch trap, cleared by reset
    run_cmd(3'd3, 2, 64'd0, I64);
    run_cmd(3'd1, 0, 64'd1, F32);

    // 5: bound faults and exact fits
    run_cmd(3'd3, 2, 64'd0, I32);
    run_cmd(3'd0, 2, 64'd0, I32);
    run_cmd(3'd4, 0, 64'd0, I32);
    run_cmd(3'd0, 0, 64'd0, I32);
    run_cmd(3'd3, 128, 64'd0, F64);
    run_cmd(3'd0, 127, 64'd0, F64);
    run_cmd(3'd3, 1, 64'd0, F64);
    for (int i = 0; i < 16; i++) run_cmd(3'd3, 0, 64'd0, I32);
    check_eq("t5_full_depth", frame_depth, 16);
    run_cmd(3'd3, 0, 64'd0, I32);
    run_cmd(3'd6, 0, 64'd0, I32);

    // 6: reset during frame clearing aborts the push
    cmd_valid = 1'b1; cmd_op = 3'd3; cmd_index = 8'd4; cmd_type = I32;
    @(negedge clk);
    cmd_valid = 1'b0;
    saw = 1'b0;
    repeat (2) begin @(negedge clk); saw = saw | rsp_valid; end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    fr_base.delete();
    fr_size.delete();
    repeat (8) begin saw = saw | rsp_valid; @(negedge clk); end
    check_eq("t6_no_rsp", saw, 0);
    check_eq("t6_depth", frame_depth, 0);
    check_eq("t6_ready", cmd_ready, 1);
    check_eq("t6_trap", trap, 0);

    // Random command stream
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      s = cur_size();
      d = fr_base.size();
      typ = 2'($urandom_range(0, 3));
      if (r < 25) begin
        idx = (r < 2) ? $urandom_range(0, 130) : $urandom_range(0, 8);
        run_cmd(3'd3, idx, 64'd0, typ);
      end else if (r < 38) begin
        run_cmd(3'd4, 0, 64'd0, typ);
      end else if (r < 63) begin
        run_cmd(3'd0, $urandom_range(0, s + 1), 64'd0, typ);
      end else if (r < 97) begin
        idx = $urandom_range(0, s);
        if (d > 0 && idx < s && $urandom_range(0, 99) < 85) typ = m_type[cur_base() + idx];
        run_cmd((r < 80) ? 3'd1 : 3'd2, idx, {$urandom, $urandom}, typ);
      end else begin
        run_cmd(3'($urandom_range(5, 7)), $urandom_range(0, 8), 64'd0, typ);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
